// File: rtl/orbit_euler_stepper.sv
// Two-body orbit integrator: semi-implicit Euler steps in signed fixed point,
// one (x, y) sample per step handed out over a valid/ready port.
module orbit_euler_stepper #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 16,
  parameter int unsigned NW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x0,
  input  logic [W-1:0]  y0,
  input  logic [W-1:0]  vx0,
  input  logic [W-1:0]  vy0,
  input  logic [W-1:0]  gm,
  input  logic [W-1:0]  dt,
  input  logic [NW-1:0] nsteps,
  output logic          busy,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic [W-1:0]  sample_x,
  output logic [W-1:0]  sample_y,
  output logic [NW-1:0] sample_idx,
  output logic          done,
  output logic          err
);

  localparam int unsigned CW = $clog2(W);
  localparam logic signed [2*W+1:0] MaxS = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W+1:0] MinS = {{(W+3){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0] MaxW = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [3:0] {
    StIdle, StSq, StSqrt, StCube, StDiv, StAcc, StVel, StPos, StEmit, StFin
  } state_e;

  // Clamp a wide signed value to W bits; MSB of the result flags saturation.
  function automatic logic [W:0] sat(input logic signed [2*W+1:0] v);
    if (v > MaxS) return {1'b1, MaxW};
    if (v < MinS) return {1'b1, ~MaxW};
    return {1'b0, v[W-1:0]};
  endfunction

  // (+/- a*b) >>> FRAC, negation applied before the shift so rounding is toward -inf.
  function automatic logic [W:0] mul_sh(input logic signed [W-1:0] a,
                                        input logic signed [W-1:0] b,
                                        input logic neg);
    logic signed [2*W+1:0] p;
    p = a * b;
    if (neg) p = -p;
    return sat(p >>> FRAC);
  endfunction

  function automatic logic [W:0] add_sat(input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b);
    logic signed [2*W+1:0] s;
    s = a + b;
    return sat(s);
  endfunction

  state_e state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic signed [W-1:0] gm_q, gm_d, dt_q, dt_d, k_q, k_d, ax_q, ax_d, ay_q, ay_d;
  logic [NW-1:0] nsteps_q, nsteps_d, idx_q, idx_d, sidx_q, sidx_d;
  logic [2*W-1:0] r2_q, r2_d, rad_q, rad_d;
  logic [W+1:0] rem_q, rem_d;
  logic [W-1:0] root_q, root_d, r3_q, r3_d, drem_q, drem_d, quot_q, quot_d;
  logic [W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, err_q, err_d;

  // Combinational datapath temporaries
  logic signed [2*W-1:0] xx, yy;
  logic [2*W-1:0] r2_sum, dvd, dsh;
  logic [3*W-1:0] p3, r3w;
  logic [W-1:0] r3v;
  logic r3sat, sq_ge, dv_ge, last;
  logic [W+1:0] sq_t, sq_trial;
  logic [W:0] dv_t, dv_diff;
  logic [W:0] acc_x, acc_y, dvx, dvy, nvx, nvy, dpx, dpy, npx, npy;
  logic [NW-1:0] idx_inc;

  // Next-state logic: one datapath phase per state.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;      y_d    = y_q;    vx_d   = vx_q;   vy_d = vy_q;
    gm_d     = gm_q;     dt_d   = dt_q;   k_d    = k_q;    ax_d = ax_q;  ay_d = ay_q;
    nsteps_d = nsteps_q; idx_d  = idx_q;  sidx_d = sidx_q;
    r2_d     = r2_q;     rad_d  = rad_q;  rem_d  = rem_q;  root_d = root_q;
    r3_d     = r3_q;     drem_d = drem_q; quot_d = quot_q; ovf_d  = ovf_q;
    sx_d     = sx_q;     sy_d   = sy_q;   cnt_d  = cnt_q;  err_d  = err_q;

    xx       = x_q * x_q;
    yy       = y_q * y_q;
    r2_sum   = $unsigned(xx) + $unsigned(yy);
    p3       = r2_q * root_q;
    r3w      = p3 >> (2 * FRAC);
    r3sat    = |r3w[3*W-1:W-1];
    r3v      = r3sat ? MaxW : r3w[W-1:0];
    dvd      = {{(W-FRAC){1'b0}}, gm_q, {FRAC{1'b0}}};
    // Quotient >= 2^(W-1) exactly when the dividend reaches r3 << (W-1).
    dsh      = {1'b0, r3v, {(W-1){1'b0}}};
    sq_t     = {rem_q[W-1:0], rad_q[2*W-1 -: 2]};
    sq_trial = {root_q, 2'b01};
    sq_ge    = sq_t >= sq_trial;
    dv_t     = {drem_q, quot_q[W-1]};
    dv_ge    = dv_t >= {1'b0, r3_q};
    dv_diff  = dv_t - {1'b0, r3_q};
    last     = cnt_q == CW'(W - 1);
    acc_x    = mul_sh(k_q, x_q, 1'b1);
    acc_y    = mul_sh(k_q, y_q, 1'b1);
    dvx      = mul_sh(ax_q, dt_q, 1'b0);
    dvy      = mul_sh(ay_q, dt_q, 1'b0);
    nvx      = add_sat(vx_q, dvx[W-1:0]);
    nvy      = add_sat(vy_q, dvy[W-1:0]);
    dpx      = mul_sh(vx_q, dt_q, 1'b0);
    dpy      = mul_sh(vy_q, dt_q, 1'b0);
    npx      = add_sat(x_q, dpx[W-1:0]);
    npy      = add_sat(y_q, dpy[W-1:0]);
    idx_inc  = idx_q + NW'(1);

    case (state_q)
      StIdle: begin
        if (start) begin
          x_d = x0;  y_d = y0;  vx_d = vx0;  vy_d = vy0;
          gm_d = gm; dt_d = dt; nsteps_d = nsteps;
          idx_d = '0;
          err_d = 1'b0;
          state_d = (nsteps != '0) ? StSq : StFin;
        end
      end
      StSq: begin
        r2_d    = r2_sum;
        rad_d   = r2_sum;
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = StSqrt;
      end
      StSqrt: begin
        rad_d  = rad_q << 2;
        rem_d  = sq_ge ? (sq_t - sq_trial) : sq_t;
        root_d = {root_q[W-2:0], sq_ge};
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = StCube;
        end
      end
      StCube: begin
        if (r3v == '0) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          r3_d    = r3v;
          drem_d  = dvd[2*W-1:W];
          quot_d  = dvd[W-1:0];
          ovf_d   = dvd >= dsh;
          cnt_d   = '0;
          err_d   = err_q | r3sat;
          state_d = StDiv;
        end
      end
      StDiv: begin
        drem_d = dv_ge ? dv_diff[W-1:0] : dv_t[W-1:0];
        quot_d = {quot_q[W-2:0], dv_ge};
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          k_d     = ovf_q ? MaxW : quot_d;
          err_d   = err_q | ovf_q;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        ax_d    = acc_x[W-1:0];
        ay_d    = acc_y[W-1:0];
        err_d   = err_q | acc_x[W] | acc_y[W];
        state_d = StVel;
      end
      StVel: begin
        vx_d    = nvx[W-1:0];
        vy_d    = nvy[W-1:0];
        err_d   = err_q | dvx[W] | dvy[W] | nvx[W] | nvy[W];
        state_d = StPos;
      end
      StPos: begin
        x_d     = npx[W-1:0];
        y_d     = npy[W-1:0];
        sx_d    = npx[W-1:0];
        sy_d    = npy[W-1:0];
        sidx_d  = idx_q;
        err_d   = err_q | dpx[W] | dpy[W] | npx[W] | npy[W];
        state_d = StEmit;
      end
      StEmit: begin
        if (sample_ready) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == nsteps_q) ? StFin : StSq;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q <= '0;  y_q <= '0;  vx_q <= '0;  vy_q <= '0;
      gm_q <= '0; dt_q <= '0; k_q <= '0;   ax_q <= '0;  ay_q <= '0;
      nsteps_q <= '0; idx_q <= '0; sidx_q <= '0;
      r2_q <= '0; rad_q <= '0; rem_q <= '0; root_q <= '0;
      r3_q <= '0; drem_q <= '0; quot_q <= '0; ovf_q <= 1'b0;
      sx_q <= '0; sy_q <= '0; cnt_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;  y_q <= y_d;  vx_q <= vx_d;  vy_q <= vy_d;
      gm_q <= gm_d; dt_q <= dt_d; k_q <= k_d;   ax_q <= ax_d;  ay_q <= ay_d;
      nsteps_q <= nsteps_d; idx_q <= idx_d; sidx_q <= sidx_d;
      r2_q <= r2_d; rad_q <= rad_d; rem_q <= rem_d; root_q <= root_d;
      r3_q <= r3_d; drem_q <= drem_d; quot_q <= quot_d; ovf_q <= ovf_d;
      sx_q <= sx_d; sy_q <= sy_d; cnt_q <= cnt_d; err_q <= err_d;
    end
  end

  // Status outputs decode the registered state.
  always_comb begin
    busy         = state_q != StIdle;
    sample_valid = state_q == StEmit;
    done         = state_q == StFin;
    sample_x     = sx_q;
    sample_y     = sy_q;
    sample_idx   = sidx_q;
    err          = err_q;
  end

endmodule

// File: tb/tb_orbit_euler_stepper.sv
// Directed bench for orbit_euler_stepper (W=32, FRAC=16).
module tb_orbit_euler_stepper;
  localparam int W = 32;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst, start, sample_ready;
  logic [W-1:0] x0, y0, vx0, vy0, gm, dt;
  logic [NW-1:0] nsteps;
  logic busy, sample_valid, done, err;
  logic [W-1:0] sample_x, sample_y;
  logic [NW-1:0] sample_idx;

  int errs = 0;
  int checks = 0;

  orbit_euler_stepper #(.W(32), .FRAC(16), .NW(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .vx0(vx0), .vy0(vy0), .gm(gm), .dt(dt), .nsteps(nsteps),
    .busy(busy), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_x(sample_x), .sample_y(sample_y), .sample_idx(sample_idx),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_nominal();
    x0 = 32'h0001_0000; y0 = 32'h0; vx0 = 32'h0; vy0 = 32'h0001_0000;
    gm = 32'h0001_0000; dt = 32'h0000_1000; nsteps = 16'd4;
  endtask

  // Leaves the caller at the falling edge just after the accepting edge.
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Counts rising edges until sample_valid is seen, bounded.
  task automatic wait_valid(input int c0, output int cyc);
    cyc = c0;
    while (!sample_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_valid"}, sample_valid, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_xyi"}, {sample_x, sample_y, sample_idx}, 0);
  endtask

  task automatic run_nominal(input bit poke);
    int cyc;
    int c0;
    set_nominal();
    sample_ready = 1'b1;
    do_start();
    check_eq("nom_busy", busy, 1);
    check_eq("nom_err_clr", err, 0);
    c0 = 0;
    if (poke) begin
      x0 = 32'h0005_0000; nsteps = 16'd1; start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      c0 = 3;
    end
    for (int i = 0; i < 4; i++) begin
      wait_valid((i == 0) ? c0 : 0, cyc);
      check_eq("nom_lat", cyc, 69);
      check_eq("nom_idx", sample_idx, i);
      if (i == 0) begin
        check_eq("nom_x0", sample_x, 32'h0000_FF00);
        check_eq("nom_y0", sample_y, 32'h0000_1000);
      end
      if (i == 1) begin
        check_eq("nom_x1", sample_x, 32'h0000_FCFF);
        check_eq("nom_y1", sample_y, 32'h0000_1FEF);
      end
      @(negedge clk);
    end
    check_eq("nom_done", done, 1);
    check_eq("nom_err", err, 0);
    @(negedge clk);
    check_eq("nom_done_pulse", done, 0);
    check_eq("nom_busy_end", busy, 0);
  endtask

  initial begin
    int cyc;
    int nvalid;
    int bad;
    logic [W-1:0] hx, hy;

    rst = 1'b1; start = 1'b0; sample_ready = 1'b1;
    set_nominal();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_nominal(1'b0);

    // nsteps = 0: straight to FIN
    set_nominal(); nsteps = 16'd0;
    do_start();
    check_eq("n0_done", done, 1);
    check_eq("n0_busy", busy, 1);
    check_eq("n0_valid", sample_valid, 0);
    @(negedge clk);
    check_eq("n0_done_end", done, 0);
    check_eq("n0_busy_end", busy, 0);

    // Zero radius aborts at CUBE
    set_nominal(); x0 = '0; y0 = '0; nsteps = 16'd3;
    do_start();
    cyc = 0; nvalid = 0;
    while (!done && cyc < 300) begin
      if (sample_valid) nvalid++;
      @(negedge clk);
      cyc++;
    end
    check_eq("zr_done_cyc", cyc, 34);
    check_eq("zr_err", err, 1);
    check_eq("zr_nsamp", nvalid, 0);
    @(negedge clk);
    check_eq("zr_busy_end", busy, 0);
    check_eq("zr_err_sticky", err, 1);

    // Back-pressure on the first sample, then reset in the middle of a later DIV
    set_nominal(); sample_ready = 1'b0;
    do_start();
    wait_valid(0, cyc);
    check_eq("st_lat", cyc, 69);
    hx = sample_x; hy = sample_y; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!sample_valid || sample_x !== hx || sample_y !== hy || sample_idx !== 0) bad++;
    end
    check_eq("st_stable", bad, 0);
    check_eq("st_x", sample_x, 32'h0000_FF00);
    sample_ready = 1'b1;
    @(negedge clk);
    wait_valid(0, cyc);
    check_eq("st_lat2", cyc, 69);
    check_eq("st_idx2", sample_idx, 1);
    check_eq("st_x2", sample_x, 32'h0000_FCFF);
    @(negedge clk);
    repeat (40) @(negedge clk);
    check_eq("ab_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check_eq("ab_no_done", bad, 0);

    run_nominal(1'b0);

    // Tiny radius with huge gm: divider saturates, run still completes
    x0 = 32'h0000_1000; y0 = '0; vx0 = '0; vy0 = '0;
    gm = 32'h7FFF_FFFF; dt = 32'h0000_1000; nsteps = 16'd1;
    do_start();
    wait_valid(0, cyc);
    check_eq("sat_lat", cyc, 69);
    check_eq("sat_x", sample_x, 32'hFFF8_1000);
    check_eq("sat_y", sample_y, 32'h0);
    check_eq("sat_err", err, 1);
    @(negedge clk);
    check_eq("sat_done", done, 1);
    @(negedge clk);

    run_nominal(1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
